apb_m: RTL

APB master bridge that sits directly upstream of the 16x8 APB memory slave. It accepts single read/write commands on a valid/ready request port and runs one APB SETUP→ACCESS transfer per command. It returns read data and error status on a valid/ready response port. A per-transfer wait-state watchdog guarantees completion when a slave never asserts pready.

---
 rtl/apb_m_pkg.sv | 28 ++
 rtl/apb_m_if.sv | 33 +++
 rtl/apb_m_wdt.sv | 45 ++++
 rtl/apb_m.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_m_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg : definitions shared by the APB master bridge, its watchdog and the
//           16x8 APB memory slave environment.
//   apb_state_e    : master FSM state encoding (2-bit)
//   APB_ADDR_W     : default address width
//   APB_DATA_W     : default data width
//   APB_MEM_DEPTH  : number of locations in the downstream memory slave
//   is_bus_active  : true for the states in which psel is driven
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 8;
    localparam int APB_MEM_DEPTH = 16;

    // psel is owned by the master only while a transfer is on the bus
    function automatic logic is_bus_active(input apb_state_e s);
        return (s == SETUP) || (s == ACCESS);
    endfunction

endpackage

// File: rtl/apb_m_if.sv
// ---------------------------------------------------------------------------
// apb_m_if : APB bus bundle between the master bridge and a slave.
//   master modport : drives paddr/psel/penable/pwrite/pwdata,
//                    receives prdata/pready/pslverr
//   slave modport  : the mirror image
// ---------------------------------------------------------------------------
interface apb_m_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_m_wdt.sv
// ---------------------------------------------------------------------------
// apb_m_wdt : wait-state watchdog for one APB ACCESS phase.
//   pclk    : clock
//   presetn : synchronous active-low reset (counter to zero)
//   clr     : force the counter to zero
//   ld      : load TIMEOUT-1 (start of a new transfer)
//   en      : count one ACCESS cycle without pready
//   expired : counter has reached zero, i.e. this is the TIMEOUT-th
//             ACCESS cycle since the load
// ---------------------------------------------------------------------------
module apb_m_wdt #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr,
    input  logic ld,
    input  logic en,
    output logic expired
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter: first ACCESS cycle sees TIMEOUT-1, the TIMEOUT-th sees zero
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (ld) begin
            cnt_r <= LOAD_VAL;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == '0);

endmodule

// File: rtl/apb_m.sv
// ---------------------------------------------------------------------------
// apb_m : APB master bridge. Accepts one read/write command at a time on a
//         valid/ready request port, runs a single SETUP->ACCESS transfer and
//         returns the result on a valid/ready response port. A watchdog
//         forces an error completion when pready never arrives.
//   pclk, presetn          : clock, synchronous active-low reset
//   req_valid/req_ready    : request handshake
//   req_write/addr/wdata   : command fields
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata/err/timeout  : response fields
//   apb (master modport)   : paddr/psel/penable/pwrite/pwdata out,
//                            prdata/pready/pslverr in
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module apb_m
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_m_if.master           apb
);

    apb_state_e        state_r;
    apb_state_e        state_nx_s;

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              rsp_timeout_r;
    logic [ADDR_W-1:0] paddr_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [DATA_W-1:0] pwdata_r;

    logic              accept_s;
    logic              done_s;
    logic              expire_s;
    logic              wdt_expired_s;

    // req_ready_r qualifies the accept so no command is taken in the first
    // IDLE cycle after reset, while req_ready is still low
    assign accept_s = (state_r == IDLE) && req_ready_r && req_valid;
    assign done_s   = (state_r == ACCESS) && apb.pready;
    assign expire_s = (state_r == ACCESS) && !apb.pready && wdt_expired_s;

    apb_m_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .pclk    (pclk),
        .presetn (presetn),
        .clr     (state_r == RESP),
        .ld      (accept_s),
        .en      (state_r == ACCESS),
        .expired (wdt_expired_s)
    );

    // State register
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = SETUP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: begin
                state_nx_s = ACCESS;
            end
            ACCESS: begin
                if (done_s || expire_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Handshake/strobe outputs are registered from the next state so they
    // line up with the state they describe
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            req_ready_r <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_nx_s == IDLE);
            psel_r      <= is_bus_active(state_nx_s);
            penable_r   <= (state_nx_s == ACCESS);
            rsp_valid_r <= (state_nx_s == RESP);
        end
    end

    // Command capture; the bus fields then stay put until the next accept
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            paddr_r  <= '0;
            pwrite_r <= 1'b0;
            pwdata_r <= '0;
        end else if (accept_s) begin
            paddr_r  <= req_addr;
            pwrite_r <= req_write;
            pwdata_r <= req_wdata;
        end else begin
            paddr_r  <= paddr_r;
            pwrite_r <= pwrite_r;
            pwdata_r <= pwdata_r;
        end
    end

    // Response capture at the end of ACCESS; held through RESP
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (done_s) begin
            rsp_err_r     <= apb.pslverr;
            rsp_timeout_r <= 1'b0;
            if (!pwrite_r && !apb.pslverr) begin
                rsp_rdata_r <= apb.prdata;
            end else begin
                rsp_rdata_r <= '0;
            end
        end else if (expire_s) begin
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else begin
            rsp_rdata_r   <= rsp_rdata_r;
            rsp_err_r     <= rsp_err_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

    assign apb.paddr   = paddr_r;
    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.pwdata  = pwdata_r;

endmodule
